alu_cmd_seq: RTL and testbench

Sequential command front-end that drives the combinational ALU's operand/opsel inputs and collects its results and flags. Accepts commands over a valid/ready stream and buffers them in a small FIFO. Issues one command at a time to the ALU, waits a fixed settle time, then captures result_l/result_h and the four flags. Returns them on a second valid/ready stream to the register-file writeback.

---
 rtl/alu_cmd_seq_if.sv | 44 ++++
 rtl/alu_cmd_seq.sv | 205 ++++++++++++++++++++
 tb/tb_alu_cmd_seq.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_seq_if.sv
// Command, ALU-side and response signal bundle for alu_cmd_seq.
// slave = sequencer view, master = command source / ALU / consumer view.
interface alu_cmd_seq_if #(
  parameter int DATA_W  = 16,
  parameter int OPSEL_W = 6
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [DATA_W-1:0]  cmd_a;
  logic [DATA_W-1:0]  cmd_b;
  logic [OPSEL_W-1:0] cmd_opsel;

  logic [DATA_W-1:0]  alu_op_a;
  logic [DATA_W-1:0]  alu_op_b;
  logic [OPSEL_W-1:0] alu_opsel;
  logic [DATA_W-1:0]  alu_res_l;
  logic [DATA_W-1:0]  alu_res_h;
  logic [3:0]         alu_flags;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_W-1:0]  rsp_res_l;
  logic [DATA_W-1:0]  rsp_res_h;
  logic [3:0]         rsp_flags;
  logic               rsp_err;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_opsel,
    output cmd_ready,
    output alu_op_a, alu_op_b, alu_opsel,
    input  alu_res_l, alu_res_h, alu_flags,
    output rsp_valid, rsp_res_l, rsp_res_h, rsp_flags, rsp_err,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_opsel,
    input  cmd_ready,
    input  alu_op_a, alu_op_b, alu_opsel,
    output alu_res_l, alu_res_h, alu_flags,
    input  rsp_valid, rsp_res_l, rsp_res_h, rsp_flags, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_cmd_seq.sv
// Command FIFO + sequencer that issues one command at a time to a combinational ALU and returns its results.
// Optional divide-by-zero trap: define ALU_CMD_SEQ_DIV0_TRAP_EN.
module alu_cmd_seq #(
  parameter int DATA_W     = 16,
  parameter int OPSEL_W    = 6,
  parameter int OPC_MSB    = 5,
  parameter int OPC_LSB    = 3,
  parameter int DIV_OPC    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_cmd_seq_if.slave  bus,
  output logic          busy
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int CMD_W = 2 * DATA_W + OPSEL_W;
  localparam int OPC_W = OPC_MSB - OPC_LSB + 1;
  localparam int SW    = 4;
`ifdef ALU_CMD_SEQ_DIV0_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_HOLD} state_e;

  logic [CMD_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  state_e             state_q, state_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic               trap_q, trap_d;
  logic [DATA_W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [OPSEL_W-1:0] opsel_q, opsel_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  res_l_q, res_l_d, res_h_q, res_h_d;
  logic [3:0]         flags_q, flags_d;
  logic               err_q, err_d;

  logic               push_s, pop_s, div_zero_s, trap_s;
  logic [DATA_W-1:0]  head_a_s, head_b_s;
  logic [OPSEL_W-1:0] head_opsel_s;

  assign push_s = bus.cmd_valid && cmd_ready_q;
  assign {head_a_s, head_b_s, head_opsel_s} = mem_q[rd_ptr_q];
  assign div_zero_s = (head_opsel_s[OPC_MSB:OPC_LSB] == OPC_W'(DIV_OPC)) &&
                      (head_b_s == {DATA_W{1'b0}});
  assign trap_s = TRAP_EN && div_zero_s;

  // Sequencer next state: issue, settle countdown, capture, response hold
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trap_d      = trap_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    opsel_d     = opsel_q;
    rsp_valid_d = rsp_valid_q;
    res_l_d     = res_l_q;
    res_h_d     = res_h_q;
    flags_d     = flags_q;
    err_d       = err_q;
    pop_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != {CW{1'b0}}) begin
          pop_s = 1'b1;
          if (trap_s) begin
            trap_d  = 1'b1;
            state_d = ST_CAPTURE;
          end else begin
            trap_d  = 1'b0;
            op_a_d  = head_a_s;
            op_b_d  = head_b_s;
            opsel_d = head_opsel_s;
            cnt_d   = SW'(SETTLE_CYC);
            state_d = ST_SETTLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_CAPTURE: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_HOLD;
        if (trap_q) begin
          res_l_d = {DATA_W{1'b0}};
          res_h_d = {DATA_W{1'b0}};
          flags_d = 4'b0011;
          err_d   = 1'b1;
        end else begin
          res_l_d = bus.alu_res_l;
          res_h_d = bus.alu_res_h;
          flags_d = bus.alu_flags;
          err_d   = 1'b0;
        end
      end
      ST_HOLD: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO pointer/count update; ready and busy are registered from next-cycle values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    cmd_ready_d = (count_d != CW'(FIFO_DEPTH));
    busy_d      = (state_d != ST_IDLE) || (count_d != {CW{1'b0}});
  end

  // Command storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {bus.cmd_a, bus.cmd_b, bus.cmd_opsel};
    end
  end

  // All control and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {SW{1'b0}};
      trap_q      <= 1'b0;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      op_a_q      <= {DATA_W{1'b0}};
      op_b_q      <= {DATA_W{1'b0}};
      opsel_q     <= {OPSEL_W{1'b0}};
      rsp_valid_q <= 1'b0;
      res_l_q     <= {DATA_W{1'b0}};
      res_h_q     <= {DATA_W{1'b0}};
      flags_q     <= 4'b0000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      trap_q      <= trap_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      opsel_q     <= opsel_d;
      rsp_valid_q <= rsp_valid_d;
      res_l_q     <= res_l_d;
      res_h_q     <= res_h_d;
      flags_q     <= flags_d;
      err_q       <= err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.alu_op_a  = op_a_q;
  assign bus.alu_op_b  = op_b_q;
  assign bus.alu_opsel = opsel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_res_l = res_l_q;
  assign bus.rsp_res_h = res_h_q;
  assign bus.rsp_flags = flags_q;
  assign bus.rsp_err   = err_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq: directed vector table, multi-cycle corner sequences
// and randomized streams scored against a queue-based reference model with a behavioural ALU.
module tb_alu_cmd_seq;
  localparam int DATA_W     = 16;
  localparam int OPSEL_W    = 6;
  localparam int FIFO_DEPTH = 4;
  localparam int SETTLE_CYC = 2;

  typedef struct packed {
    logic [15:0] res_l;
    logic [15:0] res_h;
    logic [3:0]  flags;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  op;
    logic [15:0] res_l;
    logic [15:0] res_h;
    logic [3:0]  flags;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_rsp = 0;
  rsp_t exp_q[$];
  rsp_t alu_r;
  rsp_t held;
  logic hold_chk = 1'b0;

  alu_cmd_seq_if #(.DATA_W(DATA_W), .OPSEL_W(OPSEL_W)) bus ();

  alu_cmd_seq #(
    .DATA_W(DATA_W), .OPSEL_W(OPSEL_W), .OPC_MSB(5), .OPC_LSB(3), .DIV_OPC(3),
    .FIFO_DEPTH(FIFO_DEPTH), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: opcode 0 ADD, 1 SUB, 2 MUL, 3 DIV, others invalid (all zero)
  function automatic rsp_t alu_ref(input logic [15:0] a, input logic [15:0] b, input logic [5:0] op);
    rsp_t r;
    logic [16:0] s;
    logic [31:0] p;
    r = '0;
    case (op[5:3])
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r.res_l = s[15:0];
        r.flags = {(a[15] == b[15]) && (s[15] != a[15]), s[16], 1'b0, s[15:0] == 16'd0};
      end
      3'd1: begin
        s = {1'b0, a} - {1'b0, b};
        r.res_l = s[15:0];
        r.flags = {(a[15] != b[15]) && (s[15] != a[15]), a < b, 1'b0, s[15:0] == 16'd0};
      end
      3'd2: begin
        p = {16'd0, a} * {16'd0, b};
        r.res_l = p[15:0];
        r.res_h = p[31:16];
        r.flags = {2'b00, p[31:16] == 16'd0, p[15:0] == 16'd0};
      end
      3'd3: begin
        if (b != 16'd0) begin
          r.res_l = a / b;
          r.res_h = a % b;
          r.flags = {2'b00, r.res_h == 16'd0, r.res_l == 16'd0};
        end else begin
          r.res_l = 16'hFFFF;
          r.res_h = a;
          r.flags = 4'b1000;
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Expected response for one command, including the optional trap rule
  function automatic rsp_t exp_rsp(input logic [15:0] a, input logic [15:0] b, input logic [5:0] op);
    rsp_t r;
    r = alu_ref(a, b, op);
`ifdef ALU_CMD_SEQ_DIV0_TRAP_EN
    if (op[5:3] == 3'd3 && b == 16'd0) begin
      r.res_l = 16'd0;
      r.res_h = 16'd0;
      r.flags = 4'b0011;
      r.err   = 1'b1;
    end
`endif
    return r;
  endfunction

  always_comb alu_r = alu_ref(bus.alu_op_a, bus.alu_op_b, bus.alu_opsel);
  assign bus.alu_res_l = alu_r.res_l;
  assign bus.alu_res_h = alu_r.res_h;
  assign bus.alu_flags = alu_r.flags;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: order/value of every accepted response, and stability while stalled
  always @(negedge clk) begin
    rsp_t cur;
    rsp_t e;
    cur = {bus.rsp_res_l, bus.rsp_res_h, bus.rsp_flags, bus.rsp_err};
    if (!rst_n) begin
      exp_q.delete();
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        check("rsp_hold_stable", {bus.rsp_valid, cur}, {1'b1, held});
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        exp_q.push_back(exp_rsp(bus.cmd_a, bus.cmd_b, bus.cmd_opsel));
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_spurious: got response %0h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          check("rsp_scoreboard", cur, e);
        end
      end
      hold_chk = bus.rsp_valid && !bus.rsp_ready;
      held = cur;
    end
  end

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (!busy && !bus.rsp_valid && exp_q.size() == 0) done = 1'b1;
    end
    check("drain_complete", done, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic gen_cmd();
    bus.cmd_a = 16'($urandom);
    bus.cmd_b = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 15));
    bus.cmd_opsel = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
  endtask

  // mode 0: rsp_ready toggles every cycle; mode 1: random valid/ready
  task automatic run_stream(input int n, input int mode);
    int idx;
    int start;
    bit acc;
    idx = 0;
    start = n_rsp;
    gen_cmd();
    for (int cyc = 0; cyc < 60 * n && !(idx == n && n_rsp == start + n); cyc++) begin
      if (mode == 0) bus.rsp_ready = ~bus.rsp_ready;
      else bus.rsp_ready = 1'($urandom_range(0, 1));
      if (idx < n) bus.cmd_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      else bus.cmd_valid = 1'b0;
      @(negedge clk);
      acc = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        gen_cmd();
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    check("stream_accepted", idx, n);
    check("stream_rsp_count", n_rsp - start, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    logic [15:0] prev_a, prev_b;
    int lat;
    bit found;
    int seen;

    vecs[0] = '{16'd5,     16'd3,     6'b000000, 16'd8,     16'd0,     4'b0000, 1'b0};
    vecs[1] = '{16'h0100,  16'h0100,  6'b010000, 16'h0000,  16'h0001,  4'b0001, 1'b0};
    vecs[2] = '{16'hFFFF,  16'h0001,  6'b000000, 16'h0000,  16'h0000,  4'b0101, 1'b0};
    vecs[3] = '{16'h0003,  16'h0005,  6'b001000, 16'hFFFE,  16'h0000,  4'b0100, 1'b0};
    vecs[4] = '{16'h7FFF,  16'h0001,  6'b000000, 16'h8000,  16'h0000,  4'b1000, 1'b0};
    vecs[5] = '{16'h1234,  16'h5678,  6'b111000, 16'h0000,  16'h0000,  4'b0000, 1'b0};
    vecs[6] = '{16'hFFFF,  16'hFFFF,  6'b010000, 16'h0001,  16'hFFFE,  4'b0000, 1'b0};
    vecs[7] = '{16'h0007,  16'h0002,  6'b011000, 16'h0003,  16'h0001,  4'b0000, 1'b0};
`ifdef ALU_CMD_SEQ_DIV0_TRAP_EN
    vecs[8] = '{16'h0007,  16'h0000,  6'b011000, 16'h0000,  16'h0000,  4'b0011, 1'b1};
`else
    vecs[8] = '{16'h0007,  16'h0000,  6'b011000, 16'hFFFF,  16'h0007,  4'b1000, 1'b0};
`endif

    bus.cmd_valid = 1'b0;
    bus.cmd_a = 16'd0;
    bus.cmd_b = 16'd0;
    bus.cmd_opsel = 6'd0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("reset_cmd_ready", bus.cmd_ready, 1'b1);
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_alu_ops", {bus.alu_op_a, bus.alu_op_b, bus.alu_opsel}, 38'd0);
    check("reset_rsp_data", {bus.rsp_res_l, bus.rsp_res_h, bus.rsp_flags, bus.rsp_err}, 37'd0);
    @(posedge clk); #1;

    // Directed table: values, latency from acceptance, ALU-side operands
    prev_a = 16'd0;
    prev_b = 16'd0;
    for (int i = 0; i < 9; i++) begin
      bus.cmd_a = vecs[i].a;
      bus.cmd_b = vecs[i].b;
      bus.cmd_opsel = vecs[i].op;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      lat = 1;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
        @(negedge clk);
        if (bus.rsp_valid) found = 1'b1;
        else begin
          @(posedge clk); #1;
          lat++;
        end
      end
      check($sformatf("vec%0d_found", i), found, 1'b1);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].err ? 3 : SETTLE_CYC + 3);
      check($sformatf("vec%0d_res", i), {bus.rsp_res_l, bus.rsp_res_h}, {vecs[i].res_l, vecs[i].res_h});
      check($sformatf("vec%0d_flags_err", i), {bus.rsp_flags, bus.rsp_err}, {vecs[i].flags, vecs[i].err});
      if (!vecs[i].err) begin
        prev_a = vecs[i].a;
        prev_b = vecs[i].b;
      end
      check($sformatf("vec%0d_alu_ops", i), {bus.alu_op_a, bus.alu_op_b}, {prev_a, prev_b});
      @(posedge clk); #1;
      @(posedge clk); #1;
    end

    // Backpressure: 1 in flight + FIFO_DEPTH buffered, then in-order release
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      bus.cmd_a = 16'(i * 3 + 1);
      bus.cmd_b = 16'd100;
      bus.cmd_opsel = (i % 2 == 0) ? 6'b000000 : 6'b010000;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      check($sformatf("bp_ready_%0d", i), bus.cmd_ready, 1'b1);
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_full_ready_low", bus.cmd_ready, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_stalled_state", {bus.rsp_valid, busy, bus.cmd_ready}, 3'b110);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    wait_drain(200);

    // Reset while in SETTLE with two commands queued
    for (int i = 0; i < 3; i++) begin
      bus.cmd_a = 16'h1111 * 16'(i + 1);
      bus.cmd_b = 16'h0202;
      bus.cmd_opsel = 6'b000000;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midop_busy_before_reset", {busy, bus.rsp_valid}, 2'b10);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midop_reset_outputs", {bus.rsp_valid, bus.cmd_ready, busy}, 3'b010);
    check("midop_reset_alu_ops", {bus.alu_op_a, bus.alu_op_b, bus.alu_opsel}, 38'd0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.rsp_valid || busy) seen++;
    end
    check("midop_no_stale_activity", seen, 0);
    @(posedge clk); #1;

    // Toggling rsp_ready over 8 random commands, then a longer random stream
    bus.rsp_ready = 1'b1;
    run_stream(8, 0);
    wait_drain(200);
    run_stream(80, 1);
    wait_drain(400);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
